// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_IDX_W = 4;

    // One in-flight writer tracked by the scoreboard.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 wb_en;
        logic                 mem_r;
        logic                 s;
    } slot_t;

    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/hazard_slot_cmp.sv
// Combinational match of one shadow slot against the ID source registers.
module hazard_slot_cmp
    import hazard_scoreboard_pkg::*;
(
    input  slot_t                slot,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 use_src1,
    input  logic                 use_src2,
    output logic                 match
);

    logic hit1;
    logic hit2;

    // A slot matches when it will write a register the ID instruction reads.
    always_comb begin
        hit1  = use_src1 && (src1 == slot.dest);
        hit2  = use_src2 && (src2 == slot.dest);
        match = slot.valid && slot.wb_en && (hit1 || hit2);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard control between ID and ID/EX: tracks EXE/MEM writers, drives
// freeze/flush and counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter logic        FWD_DEFAULT = 1'b0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 use_src1,
    input  logic                 use_src2,
    input  logic [REG_IDX_W-1:0] id_dest,
    input  logic                 id_wb_en,
    input  logic                 id_mem_r_en,
    input  logic                 id_s,
    input  logic                 id_cond_use,
    input  logic                 forward_en,
    input  logic                 branch_taken,
    output logic                 freeze,
    output logic                 flush_id,
    output logic                 flush_if,
    output logic [CNT_W-1:0]     stall_cnt
);

    slot_t exe_slot;
    slot_t mem_slot;
    slot_t id_slot;
    logic  exe_match;
    logic  mem_match;
    logic  fwd_mode;
    logic  data_hazard;
    logic  status_hazard;
    logic  stall;

    hazard_slot_cmp u_cmp_exe (
        .slot     (exe_slot),
        .src1     (src1),
        .src2     (src2),
        .use_src1 (use_src1),
        .use_src2 (use_src2),
        .match    (exe_match)
    );

    hazard_slot_cmp u_cmp_mem (
        .slot     (mem_slot),
        .src1     (src1),
        .src2     (src2),
        .use_src1 (use_src1),
        .use_src2 (use_src2),
        .match    (mem_match)
    );

    // Forwarding mode follows forward_en; while reset is held the default
    // applies, which is harmless because both slots are empty then.
    assign fwd_mode = rst ? forward_en : FWD_DEFAULT;

    // Stall detection and freeze/flush priority (taken branch dominates).
    always_comb begin
        freeze        = 1'b0;
        flush_id      = 1'b0;
        flush_if      = 1'b0;
        data_hazard   = fwd_mode ? (exe_match && exe_slot.mem_r)
                                 : (exe_match || mem_match);
        data_hazard   = id_valid && data_hazard;
        status_hazard = id_valid && id_cond_use && exe_slot.valid && exe_slot.s;
        stall         = data_hazard || status_hazard;
        id_slot       = '{valid: id_valid, dest: id_dest, wb_en: id_wb_en,
                          mem_r: id_mem_r_en, s: id_s};
        if (branch_taken) begin
            flush_id = 1'b1;
            flush_if = 1'b1;
        end else if (stall) begin
            freeze   = 1'b1;
            flush_id = 1'b1;
        end
    end

    // Shadow slots: ID advances into EXE unless flushed, EXE ages into MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_slot <= BUBBLE;
            mem_slot <= BUBBLE;
        end else begin
            mem_slot <= exe_slot;
            exe_slot <= flush_id ? BUBBLE : id_slot;
        end
    end

    // Saturating count of frozen cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard control for the five-stage pipeline, sitting between the ID stage and the ID/EX pipeline register. It keeps a 2-deep shadow of in-flight writers in the EXE and MEM slots and compares them against the source registers of the instruction currently in ID. It drives the freeze for PC and IF/ID and the flush into ID/EX, so the register receives a bubble whenever the ID instruction must not issue. It also counts stall cycles for performance debug.

## Interface
- FWD_DEFAULT, 0, reset value of forwarding mode; the mode is overridden by `forward_en` each cycle.
- CNT_W, 16, width of the stall-cycle counter.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- id_valid  in  1  a real instruction occupies ID
- src1  in  4  Rn index of ID instruction
- src2  in  4  second source (Rm or Rd for store) of ID instruction
- use_src1  in  1  ID instruction reads Rn
- use_src2  in  1  ID instruction reads src2
- id_dest  in  4  destination of ID instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- id_s  in  1  ID instruction updates the status register
- id_cond_use  in  1  ID condition field is not AL
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE resolved a taken branch this cycle
- freeze  out  1  hold PC and IF/ID
- flush_id  out  1  to ID/EX flush input
- flush_if  out  1  clear IF/ID
- stall_cnt  out  CNT_W  saturating count of cycles with freeze=1

## Operation
- Shadow slots, each with {valid, dest[3:0], wb_en, mem_r, s}: EXE slot = instruction entering EXE next edge; MEM slot = previous EXE slot.
- Slot match: slot.valid & slot.wb_en & (use_src1 & src1==slot.dest | use_src2 & src2==slot.dest).
- Forwarding off: hazard = id_valid & (match EXE | match MEM).
- Forwarding on: hazard = id_valid & match EXE & EXE.mem_r. MEM slot is never a hazard.
- Status hazard, in both modes: id_valid & id_cond_use & EXE.valid & EXE.s.
- stall = hazard | status hazard.
- Priority: branch_taken dominates.
  - branch_taken=1: flush_id=1, flush_if=1, freeze=0, and stall is ignored because ID holds a wrong-path instruction.
  - Otherwise stall=1: freeze=1, flush_id=1, flush_if=0.
  - Otherwise all three are 0.
- Slot update at each rising edge:
  - MEM slot ← EXE slot.
  - EXE slot ← ID fields with valid=id_valid, but only if flush_id=0.
  - If flush_id=1, EXE slot ← bubble (valid=0, all fields 0).
- Writes in WB are not tracked. The register file writes on the falling edge.
- stall_cnt increments by 1 on each edge where freeze=1, and saturates at all-ones.

## Timing
- freeze, flush_id and flush_if are combinational from the slots plus the current inputs, with zero-cycle latency. They must settle before the edge that loads ID/EX.
- A load followed by a dependent instruction with forwarding on gives exactly one stall cycle.
- A dependent instruction with forwarding off stalls for 2 cycles if the producer is in EXE, and for 1 cycle if the producer is in MEM.
- A status hazard gives exactly 1 stall cycle.
- branch_taken together with a hazard in the same cycle gives no freeze. The following cycle then sees a bubble in EXE.
- Reset, asynchronous on rst=0 and allowed mid-stall:
  - both slots invalid and zero, stall_cnt=0;
  - outputs freeze=0, flush_id=0 and flush_if=0, since slots are empty and branch_taken is expected low during reset.
- If branch_taken is asserted during reset, flush_id and flush_if follow it combinationally. The slots still stay cleared.
- Register index 15 (PC) is compared like any other index.

## Structure
- A shared package holds:
  - the slot struct {valid, dest, wb_en, mem_r, s};
  - the BUBBLE constant;
  - the register-index width of 4.
- Sub-module `hazard_slot_cmp`: combinational match of one slot against src1/src2 and the use flags. It is instantiated twice, once per slot.
- The top level holds the slot registers, the priority logic and the counter.

## Test plan
- Forwarding on: load with id_dest=3 issued, next instruction has src1=3 and use_src1=1. Expect freeze=1 and flush_id=1 for 1 cycle, then issue; stall_cnt=1.
- Forwarding off: ADD with dest=5 issued, next instruction has src2=5 and use_src2=1. Expect freeze for 2 cycles, then issue; stall_cnt=2.
- Instruction with s=1 issued, next has id_cond_use=1 and no register match. Expect 1 stall cycle.
- Hazard present and branch_taken=1 in the same cycle. Expect freeze=0, flush_id=1, flush_if=1. On the next cycle the EXE slot is invalid, so a src match gives no stall.
- stall_cnt preloaded near saturation by holding a hazard for more than 2^CNT_W cycles, using CNT_W=4 in the bench. Expect stall_cnt to stay at 15.
- Assert rst=0 mid-stall, between the cycles of a forwarding-off 2-cycle stall. Expect freeze=0 immediately, slots clear, stall_cnt=0, and after release the same ID instruction issues without a stall.
